// File: rtl/johnson_pkg.sv
// Shared helpers for the extended Johnson counter: legality check and
// binary phase decode of a twisted-ring code.
package johnson_pkg;

    localparam int JC_MAX_WIDTH = 32;

    // A Johnson code has at most one adjacent-bit transition within its
    // active width.
    function automatic logic jc_is_legal(input logic [JC_MAX_WIDTH-1:0] value,
                                         input int width);
        int trans;
        trans = 0;
        for (int i = 0; i < JC_MAX_WIDTH - 1; i++) begin
            if (i < width - 1 && value[i] != value[i+1]) begin
                trans++;
            end
        end
        return (trans <= 1);
    endfunction

    // Filling codes (ones entering from bit 0) count up by popcount.
    // Draining codes mirror them from the top of the sequence.
    function automatic int jc_phase(input logic [JC_MAX_WIDTH-1:0] value,
                                    input int width);
        int pop;
        pop = 0;
        for (int i = 0; i < JC_MAX_WIDTH; i++) begin
            if (i < width && value[i]) begin
                pop++;
            end
        end
        if (pop == 0 || value[0]) begin
            return pop;
        end
        return 2 * width - pop;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational legality check and binary phase decode for one Johnson code.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int PW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic             legal,
    output logic [PW-1:0]    phase
);

    logic [JC_MAX_WIDTH-1:0] value_ext;

    assign value_ext = JC_MAX_WIDTH'(value);
    assign legal     = jc_is_legal(value_ext, WIDTH);
    assign phase     = PW'(jc_phase(value_ext, WIDTH));

endmodule

// File: rtl/johnson_counter_ext.sv
// Parametrised up/down Johnson counter with load, phase decode, wrap pulse
// and self-correction from illegal codes with a sticky error flag.
module johnson_counter_ext
    import johnson_pkg::*;
#(
    parameter int   WIDTH = 4,
    localparam int  PW    = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clr_err,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             err_reg, err_next;
    logic             err_set;
    logic [WIDTH-1:0] up_next, down_next;
    logic             count_legal;
    logic             load_legal;
    logic [PW-1:0]    load_phase_unused;

    johnson_decode #(.WIDTH(WIDTH), .PW(PW)) u_decode_count (
        .value (count_reg),
        .legal (count_legal),
        .phase (phase)
    );

    johnson_decode #(.WIDTH(WIDTH), .PW(PW)) u_decode_load (
        .value (load_value),
        .legal (load_legal),
        .phase (load_phase_unused)
    );

    // Ring shift wiring: the inverted end bit re-enters at the opposite end.
    assign up_next[0]          = ~count_reg[WIDTH-1];
    assign down_next[WIDTH-1]  = ~count_reg[0];
    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign up_next[gi]     = count_reg[gi-1];
            assign down_next[gi-1] = count_reg[gi];
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        err_set    = 1'b0;
        if (load) begin
            if (load_legal) begin
                count_next = load_value;
            end else begin
                count_next = '0;
                err_set    = 1'b1;
            end
        end else if (!count_legal) begin
            count_next = '0;
            err_set    = 1'b1;
        end else if (en) begin
            if (!dir) begin
                count_next = up_next;
                wrap_next  = (phase == LAST_PHASE);
            end else begin
                count_next = down_next;
                wrap_next  = (phase == '0);
            end
        end
        // A new error event outranks a simultaneous clear.
        err_next = err_set ? 1'b1 : (clr_err ? 1'b0 : err_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            err_reg   <= err_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_johnson_counter_ext.sv
// Directed bench for johnson_counter_ext at WIDTH=4 with hand-computed vectors.
module tb_johnson_counter_ext;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'h0;
    logic       clr_err = 1'b0;
    logic [3:0] count;
    logic [2:0] phase;
    logic       wrap;
    logic       err;

    int checks = 0;
    int failures = 0;

    johnson_counter_ext #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .clr_err    (clr_err),
        .count      (count),
        .phase      (phase),
        .wrap       (wrap),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [3:0] c, input logic [2:0] p,
                               input logic w, input logic e);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".phase"}, 32'(phase), 32'(p));
        check({tag, ".wrap"},  32'(wrap),  32'(w));
        check({tag, ".err"},   32'(err),   32'(e));
    endtask

    logic [3:0] up_count [10] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1, 4'h3};
    logic [2:0] up_phase [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    logic [3:0] dn_count [3]  = '{4'h8, 4'hC, 4'hE};
    logic [2:0] dn_phase [3]  = '{3'd7, 3'd6, 3'd5};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check_state("reset", 4'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Forward sequence through one wrap.
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_state($sformatf("up%0d", i), up_count[i], up_phase[i], (i == 7), 1'b0);
        end

        // Load outranks en.
        load = 1'b1; load_value = 4'hC;
        tick();
        check_state("load_c", 4'hC, 3'd6, 1'b0, 1'b0);
        load_value = 4'h0;
        tick();
        check_state("load_0", 4'h0, 3'd0, 1'b0, 1'b0);

        // Reverse from zero wraps to the top of the sequence.
        load = 1'b0; dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state($sformatf("dn%0d", i), dn_count[i], dn_phase[i], (i == 0), 1'b0);
        end

        // Illegal load: clear to zero and set sticky err.
        en = 1'b0; load = 1'b1; load_value = 4'h5;
        tick();
        check_state("bad_load", 4'h0, 3'd0, 1'b0, 1'b1);
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("sticky%0d.err", i), 32'(err), 32'd1);
        end
        clr_err = 1'b1;
        tick();
        check("clr.err", 32'(err), 32'd0);
        clr_err = 1'b0;

        // Corrupted state is corrected even with en low.
        force dut.count_reg = 4'hA;
        #1;
        release dut.count_reg;
        check("forced.count", 32'(count), 32'hA);
        tick();
        check_state("corrected", 4'h0, 3'd0, 1'b0, 1'b1);

        // Error set wins over a simultaneous clear.
        clr_err = 1'b1; load = 1'b1; load_value = 4'h5;
        tick();
        check_state("set_vs_clr", 4'h0, 3'd0, 1'b0, 1'b1);
        clr_err = 1'b0;

        // Asynchronous reset mid-sequence.
        load_value = 4'h7;
        tick();
        check_state("load_7", 4'h7, 3'd3, 1'b0, 1'b1);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 4'h0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        en = 1'b1; dir = 1'b0;
        tick();
        check_state("resume", 4'h1, 3'd1, 1'b0, 1'b0);

        // Direction change takes effect on the same cycle's step.
        dir = 1'b1;
        tick();
        check_state("dn_to_0", 4'h0, 3'd0, 1'b0, 1'b0);
        tick();
        check_state("dn_wrap", 4'h8, 3'd7, 1'b1, 1'b0);
        en = 1'b0;
        tick();
        check_state("hold", 4'h8, 3'd7, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
